aes_uart_ctrl: RTL
==================

// Module: aes_uart_ctrl
// PURPOSE
//  Byte-stream command controller between a UART byte pair (uart_rx/uart_tx) and the aes256_enc core.
//  Loads the key, loads plaintext blocks, fires the core and streams ciphertext back, so the board
//  encrypts host-supplied data rather than the fixed all-zero key/text.
//  Sits at board top level; exposes status bits for LEDs.
// PARAMETERS
//  KEY_BYTES     32      key length in bytes (16/24/32); sets aes_key width
//  BLOCK_BYTES   16      data block length in bytes
//  CLKS_PER_BIT  87      UART bit period in clk cycles (10 MHz / 115200)
//  GAP_BYTES     4       mid-frame inter-byte timeout, in byte times (10*CLKS_PER_BIT each)
// PORTS
//  clk          in   1               global clock
//  reset        in   1               asynchronous, active-high reset
//  rx_data      in   8               received byte
//  rx_valid     in   1               1-cycle strobe, rx_data valid
//  tx_data      out  8               byte to transmit
//  tx_valid     out  1               tx_data valid; held until tx_ready
//  tx_ready     in   1               uart_tx accepts byte when tx_valid&tx_ready
//  aes_start    out  1               1-cycle start pulse to core
//  aes_key      out  8*KEY_BYTES     key register
//  aes_data_in  out  8*BLOCK_BYTES   plaintext register
//  aes_data_out in   8*BLOCK_BYTES   core result
//  aes_ready    in   1               core level: high = idle/result valid
//  key_loaded   out  1               a full key has been received
//  busy         out  1               state != IDLE
//  err          out  1               sticky error; cleared by next valid command byte
// BEHAVIOUR
//  Reset: all outputs 0, key/data registers 0, key_loaded=0, state IDLE.
//  Commands (first byte in IDLE): 'K'(0x4B)+KEY_BYTES bytes; 'E'(0x45)+BLOCK_BYTES bytes; 'S'(0x53) status.
//  FSM: IDLE -> RX_KEY | RX_BLK | TX_STAT | TX_ERR; RX_KEY -> TX_ACK; RX_BLK -> START -> WAIT -> TX_BLK;
//       TX_ACK/TX_STAT/TX_ERR/TX_BLK -> IDLE when last byte accepted.
//  Byte order: first byte received lands in MSB byte [8N-1 -: 8]; TX sends MSB byte first.
//  RX_KEY: byte counter 0..KEY_BYTES-1; on last byte key_loaded=1, reply 0x06 (ACK).
//  Partial key load leaves aes_key holding the old key: bytes shift into a staging reg, copy on last.
//  'E' with key_loaded=0 -> reply 0x21 '!', err=1, payload not consumed (bytes seen as commands).
//  Unknown command byte -> reply 0x3F '?', err=1.
//  'S' -> one byte {5'b0, err, key_loaded, 1'b1}.
//  START: aes_start=1 for exactly one cycle, the cycle after the last plaintext byte.
//  WAIT: ignore aes_ready for the start cycle +1; then leave on first aes_ready=1;
//        latch aes_data_out into TX shift reg that same cycle.
//  TX_*: tx_valid held high, tx_data stable until handshake; next byte presented the following cycle.
//  Latency, last plaintext byte strobe -> aes_start: 1 cycle. Core done -> tx_valid: 1 cycle.
//  Gap timer: in RX_KEY/RX_BLK, reloads on every rx_valid; expiry at GAP_BYTES*10*CLKS_PER_BIT
//    cycles -> discard partial frame, err=1, state IDLE, no reply.
//  rx_valid outside IDLE/RX_KEY/RX_BLK: byte dropped, err=1 (overrun); no state change.
//  rx_valid on the same cycle as gap expiry: expiry wins, byte dropped.
//  Reset mid-operation: immediate return to reset values; an in-flight TX byte is abandoned.
//  Counters sized $clog2 of their max +1; no wrap beyond terminal count.
// STRUCTURE
//  aes_uart_defs.vh: command/reply byte constants, FSM state encodings, GAP_CYCLES localparam.
//  Sub-module byte_shift_reg (parametrised N bytes: load-parallel, shift-in MSB-first,
//  shift-out MSB-first) instantiated for key staging, plaintext and TX buffer.
//  Gap timer and FSM stay in aes_uart_ctrl.
// TESTING
//  1 FIPS-197 AES-256: 'K' + 00..1f, 'E' + 00112233445566778899aabbccddeeff -> 0x06,
//    then 8ea2b7ca516745bfeafc49904b496089 MSB first
//  2 'E' right after reset -> single byte 0x21, err=1, key_loaded=0; following 'S' -> 0x05.
//  3 Byte 0x7A in IDLE -> 0x3F, err=1; then 'S' -> 0x05 (err cleared by the valid 'S').
//  4 'K' + 10 bytes, then silence > GAP_BYTES*870 cycles -> busy=0, err=1, no tx, aes_key unchanged.
//  5 tx_ready held low 50 cycles during TX_BLK -> tx_data stable and no byte lost;
//    extra rx byte during WAIT -> err=1, result still correct.
//  6 reset asserted in WAIT -> all outputs 0 next edge; after release, 'S' -> 0x01.

Source files
------------

// File: rtl/aes_uart_ctrl_pkg.sv
// ============================================================================
//  Module  : aes_uart_ctrl_pkg
//  Purpose : Command/reply byte codes, FSM encodings and timing helpers
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_uart_ctrl_pkg;

    localparam logic [7:0] CMD_KEY   = 8'h4B;
    localparam logic [7:0] CMD_ENC   = 8'h45;
    localparam logic [7:0] CMD_STAT  = 8'h53;

    localparam logic [7:0] RPL_ACK   = 8'h06;
    localparam logic [7:0] RPL_NOKEY = 8'h21;
    localparam logic [7:0] RPL_UNK   = 8'h3F;

    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] S_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] S_RX_KEY  = 4'd1;
    localparam logic [STATE_W-1:0] S_RX_BLK  = 4'd2;
    localparam logic [STATE_W-1:0] S_START   = 4'd3;
    localparam logic [STATE_W-1:0] S_WAIT    = 4'd4;
    localparam logic [STATE_W-1:0] S_TX_ACK  = 4'd5;
    localparam logic [STATE_W-1:0] S_TX_STAT = 4'd6;
    localparam logic [STATE_W-1:0] S_TX_ERR  = 4'd7;
    localparam logic [STATE_W-1:0] S_TX_BLK  = 4'd8;

    // One UART byte time is 10 bit periods (start + 8 data + stop).
    function automatic int gap_cycles(input int gap_bytes, input int clks_per_bit);
        return gap_bytes * 10 * clks_per_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_uart_ctrl_byte_shift_reg.sv
// ============================================================================
//  Module  : aes_uart_ctrl_byte_shift_reg
//  Purpose : N-byte register: parallel load, MSB-first byte shift in / out
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_uart_ctrl_byte_shift_reg #(
    parameter int N_BYTES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [8*N_BYTES-1:0] load_data,
    input  logic                 shift_in,
    input  logic [7:0]           in_byte,
    input  logic                 shift_out,
    output logic [8*N_BYTES-1:0] q
);

    localparam int W = 8 * N_BYTES;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_in) begin
            q <= (q << 8) | W'(in_byte);
        end else if (shift_out) begin
            q <= q << 8;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_uart_ctrl.sv
// ============================================================================
//  Module  : aes_uart_ctrl
//  Purpose : UART byte-stream command controller feeding an AES core
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_uart_ctrl
    import aes_uart_ctrl_pkg::*;
#(
    parameter int KEY_BYTES    = 32,
    parameter int BLOCK_BYTES  = 16,
    parameter int CLKS_PER_BIT = 87,
    parameter int GAP_BYTES    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   aes_start,
    output logic [8*KEY_BYTES-1:0] aes_key,
    output logic [8*BLOCK_BYTES-1:0] aes_data_in,
    input  logic [8*BLOCK_BYTES-1:0] aes_data_out,
    input  logic                   aes_ready,
    output logic                   key_loaded,
    output logic                   busy,
    output logic                   err
);

    localparam int GAP_CYCLES = gap_cycles(GAP_BYTES, CLKS_PER_BIT);
    localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam int MAX_BYTES  = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);
    localparam int KW         = 8 * KEY_BYTES;

    logic [STATE_W-1:0]       state, state_nxt;
    logic [CNT_W-1:0]         byte_cnt;
    logic [GAP_W-1:0]         gap_cnt;
    logic                     wait_armed;
    logic [7:0]               reply;
    logic [KW-1:0]            key_stage;
    logic [8*BLOCK_BYTES-1:0] tx_buf;

    logic in_rx, gap_expire, rx_take, tx_fire;
    logic key_last, blk_last, blk_tx_last, core_done, cmd_ok;

    assign in_rx       = (state == S_RX_KEY) || (state == S_RX_BLK);
    assign gap_expire  = in_rx && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign rx_take     = in_rx && rx_valid && !gap_expire;
    assign tx_fire     = tx_valid && tx_ready;
    assign key_last    = (state == S_RX_KEY) && rx_take && (byte_cnt == CNT_W'(KEY_BYTES - 1));
    assign blk_last    = (state == S_RX_BLK) && rx_take && (byte_cnt == CNT_W'(BLOCK_BYTES - 1));
    assign blk_tx_last = tx_fire && (byte_cnt == CNT_W'(BLOCK_BYTES - 1));
    // The core's ready level is stale for the start cycle and the one after it.
    assign core_done   = (state == S_WAIT) && wait_armed && aes_ready;
    assign cmd_ok      = (rx_data == CMD_KEY) || (rx_data == CMD_STAT) ||
                         ((rx_data == CMD_ENC) && key_loaded);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_KEY)       state_nxt = S_RX_KEY;
                    else if (rx_data == CMD_STAT) state_nxt = S_TX_STAT;
                    else if (rx_data == CMD_ENC && key_loaded) state_nxt = S_RX_BLK;
                    else                          state_nxt = S_TX_ERR;
                end
            end
            S_RX_KEY:  if (gap_expire) state_nxt = S_IDLE; else if (key_last) state_nxt = S_TX_ACK;
            S_RX_BLK:  if (gap_expire) state_nxt = S_IDLE; else if (blk_last) state_nxt = S_START;
            S_START:   state_nxt = S_WAIT;
            S_WAIT:    if (core_done) state_nxt = S_TX_BLK;
            S_TX_ACK, S_TX_STAT, S_TX_ERR: if (tx_fire) state_nxt = S_IDLE;
            S_TX_BLK:  if (blk_tx_last) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        aes_start = (state == S_START);
        tx_valid  = (state == S_TX_ACK) || (state == S_TX_STAT) ||
                    (state == S_TX_ERR) || (state == S_TX_BLK);
        tx_data   = 8'h00;
        if (state == S_TX_BLK) tx_data = tx_buf[8*BLOCK_BYTES-1 -: 8];
        else if (tx_valid)     tx_data = reply;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt    <= '0;
            byte_cnt   <= '0;
            wait_armed <= 1'b0;
            reply      <= 8'h00;
            err        <= 1'b0;
            key_loaded <= 1'b0;
            aes_key    <= '0;
        end else begin
            wait_armed <= (state == S_WAIT);

            if (!in_rx || rx_valid)                     gap_cnt <= '0;
            else if (gap_cnt != GAP_W'(GAP_CYCLES - 1)) gap_cnt <= gap_cnt + GAP_W'(1);

            if (state == S_IDLE || core_done)                byte_cnt <= '0;
            else if (rx_take || (state == S_TX_BLK && tx_fire)) byte_cnt <= byte_cnt + CNT_W'(1);

            if (state == S_IDLE && rx_valid) begin
                // Status reports the error flag as it stood before this command clears it.
                err <= !cmd_ok;
                if (rx_data == CMD_STAT)     reply <= {5'b0, err, key_loaded, 1'b1};
                else if (rx_data == CMD_ENC) reply <= RPL_NOKEY;
                else                         reply <= RPL_UNK;
            end else if (gap_expire || (rx_valid && !in_rx)) begin
                err <= 1'b1;
            end

            if (key_last) begin
                reply      <= RPL_ACK;
                key_loaded <= 1'b1;
                aes_key    <= (key_stage << 8) | KW'(rx_data);
            end
        end
    end

    aes_uart_ctrl_byte_shift_reg #(.N_BYTES(KEY_BYTES)) u_key_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift_in  ((state == S_RX_KEY) && rx_take),
        .in_byte   (rx_data),
        .shift_out (1'b0),
        .q         (key_stage)
    );

    aes_uart_ctrl_byte_shift_reg #(.N_BYTES(BLOCK_BYTES)) u_plaintext (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift_in  ((state == S_RX_BLK) && rx_take),
        .in_byte   (rx_data),
        .shift_out (1'b0),
        .q         (aes_data_in)
    );

    aes_uart_ctrl_byte_shift_reg #(.N_BYTES(BLOCK_BYTES)) u_tx_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (core_done),
        .load_data (aes_data_out),
        .shift_in  (1'b0),
        .in_byte   (8'h00),
        .shift_out ((state == S_TX_BLK) && tx_fire),
        .q         (tx_buf)
    );

endmodule

`default_nettype wire
